rpn_exec: RTL and testbench
===========================

# rpn_exec

Stack execution controller for the RPN calculator. Sits between the command front end (keys/switches) and the stack RAM: accepts one command at a time, owns the stack depth counter (the stack pointer), caches the top-of-stack (TOS) in a register, and issues all read/write traffic to the synchronous-read stack RAM. Arithmetic results are pushed back in place, so the front end only sees `top`, `depth` and `error`.

## Interface
- `WIDTH`, 8: data word width.
- `AW`, 8: stack RAM address width; maximum depth `DMAX = 2^AW`.

- `CLOCK_50`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_op`  in  3  000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 MUL, 101 AND, 110 OR, 111 DUP.
- `cmd_data`  in  WIDTH  operand for PUSH; ignored otherwise.
- `cmd_ready`  out  1  high only in IDLE; command accepted on an edge where `cmd_valid & cmd_ready`.
- `ram_addr`  out  AW  stack RAM read/write address.
- `ram_wdata`  out  WIDTH  stack RAM write data.
- `ram_we`  out  1  stack RAM write enable.
- `ram_rdata`  in  WIDTH  stack RAM read data; valid the cycle after `ram_addr` is presented.
- `top`  out  WIDTH  current TOS; 0 when `depth == 0`.
- `depth`  out  AW+1  number of stack entries, 0..DMAX.
- `error`  out  1  sticky underflow/overflow flag.

## Operation
- Storage: entry `depth-1` lives in `top`; entries 0..`depth-2` live at RAM addresses 0..`depth-2` (bottom of stack at address 0).
- FSM states: IDLE, WRITE, READ, WAIT.
- IDLE, on accepted command:
  - PUSH: if `depth == DMAX` → set `error`, no state change. If `depth == 0` → `top <= cmd_data`, `depth <= 1`, stay IDLE. Else latch `cmd_data` → WRITE.
  - DUP: if `depth == 0` or `depth == DMAX` → set `error`. Else latch `top` → WRITE.
  - POP: if `depth == 0` → set `error`. If `depth == 1` → `depth <= 0`, `top <= 0`. Else latch op → READ.
  - ADD/SUB/MUL/AND/OR: if `depth < 2` → set `error`, stack unchanged. Else latch op → READ.
- WRITE: `ram_we = 1`, `ram_addr = depth-1`, `ram_wdata = top`; at the edge `top <= latched`, `depth <= depth+1` → IDLE.
- READ: `ram_addr = depth-2`, `ram_we = 0` → WAIT.
- WAIT: with `a = ram_rdata` (next-on-stack) and `b = top`:
  - POP: `top <= a`.
  - ADD `a+b`; SUB `a-b`; MUL low WIDTH bits of `a*b`; AND `a&b`; OR `a|b`.
  - All arithmetic modulo 2^WIDTH, no carry or overflow flag. `depth <= depth-1` → IDLE.
- Errored commands consume one IDLE cycle and leave `top`/`depth` untouched. `error` is cleared only by `reset`.
- `ram_addr`/`ram_wdata` are 0 outside WRITE/READ.
- `ram_we = (state == WRITE) & ~reset`.
- There is no combinational path from `cmd_*` to any output.

## Timing
- Reset (edge with `reset = 1`): state IDLE, `depth = 0`, `top = 0`, `error = 0`. `ram_we = 0` during the reset cycle. `cmd_ready = 1` from the first cycle after reset.
- Reset mid-operation aborts the command: an in-flight WRITE is suppressed and the stack returns to empty.
- Latency, accept edge to `top`/`depth` update:
  - PUSH to empty, POP from depth 1, errored command: 1 cycle.
  - PUSH/DUP from non-empty: 2 cycles.
  - POP/binary ops: 3 cycles.
- `cmd_ready` is low in WRITE/READ/WAIT. Back-to-back commands are accepted on the first IDLE edge.
- Full boundary: depth DMAX is reachable, since the last entry sits in `top` and RAM address 2^AW-1 is never written. PUSH at DMAX flags `error`; no wrap-around.

## Test plan
- Reset, then PUSH 5, PUSH 3, ADD → `top = 8`, `depth = 1`. One RAM write to addr 0 with data 5. `error = 0`.
- PUSH 3, PUSH 5, SUB → `top = 0xFE` (wrap). PUSH 0x10, MUL by 0x20 → `top = 0x00`.
- Empty stack: POP → `error = 1`, `depth = 0`. Then PUSH 7 → `top = 7`, `depth = 1`, `error` still 1.
- PUSH 1, PUSH 2, DUP, POP, POP → `top` sequence 2, 2, 2, 1; `depth` sequence 2, 3, 2, 1. Check `ram_addr` 0 then 1 on the writes and 1 then 0 on the reads.
- With AW=2: PUSH 4 values → `depth = 4`, no error. Fifth PUSH → `error = 1`, `top` and `depth` unchanged. Four POPs return 4, 3, 2, 1 in `top`; `depth` reaches 0.
- Assert `reset` during WRITE of a PUSH → `ram_we` low that cycle, next cycle `depth = 0`, `top = 0`, `cmd_ready = 1`.

Source files
------------

// File: rtl/rpn_exec.sv
// RPN stack execution controller: owns the stack pointer, caches TOS in a
// register and sequences writes/reads to a synchronous-read stack RAM.
module rpn_exec #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cmd_ready,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_we,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [WIDTH-1:0] top,
    output logic [AW:0]      depth,
    output logic             error
);

    localparam logic [AW:0] DMAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] TWO  = (AW+1)'(2);

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_DUP  = 3'b111;

    typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_t;

    state_t             state;
    logic [WIDTH-1:0]   lat_data;
    logic [2:0]         lat_op;
    logic [WIDTH-1:0]   alu;
    logic [2*WIDTH-1:0] prod;

    assign prod = {{WIDTH{1'b0}}, ram_rdata} * {{WIDTH{1'b0}}, top};

    // a = next-on-stack from RAM, b = cached TOS
    always_comb begin
        alu = ram_rdata;
        unique case (lat_op)
            OP_ADD:  alu = ram_rdata + top;
            OP_SUB:  alu = ram_rdata - top;
            OP_MUL:  alu = prod[WIDTH-1:0];
            OP_AND:  alu = ram_rdata & top;
            OP_OR:   alu = ram_rdata | top;
            default: alu = ram_rdata;
        endcase
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (state)
            WRITE: begin
                ram_addr  = AW'(depth - ONE);
                ram_wdata = top;
            end
            READ:    ram_addr = AW'(depth - TWO);
            default: ;
        endcase
    end

    assign ram_we    = (state == WRITE) & ~reset;
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            depth    <= '0;
            top      <= '0;
            error    <= 1'b0;
            lat_data <= '0;
            lat_op   <= OP_PUSH;
        end else begin
            unique case (state)
                IDLE: if (cmd_valid) begin
                    lat_op <= cmd_op;
                    unique case (cmd_op)
                        OP_PUSH: begin
                            if (depth == DMAX) begin
                                error <= 1'b1;
                            end else if (depth == '0) begin
                                top   <= cmd_data;
                                depth <= ONE;
                            end else begin
                                lat_data <= cmd_data;
                                state    <= WRITE;
                            end
                        end
                        OP_DUP: begin
                            if (depth == '0 || depth == DMAX) begin
                                error <= 1'b1;
                            end else begin
                                lat_data <= top;
                                state    <= WRITE;
                            end
                        end
                        OP_POP: begin
                            if (depth == '0) begin
                                error <= 1'b1;
                            end else if (depth == ONE) begin
                                depth <= '0;
                                top   <= '0;
                            end else begin
                                state <= READ;
                            end
                        end
                        default: begin
                            if (depth < TWO) error <= 1'b1;
                            else             state <= READ;
                        end
                    endcase
                end
                WRITE: begin
                    top   <= lat_data;
                    depth <= depth + ONE;
                    state <= IDLE;
                end
                READ: state <= WAIT;
                WAIT: begin
                    top   <= alu;
                    depth <= depth - ONE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_exec.sv
// Bench for rpn_exec (AW=2): vector table, hand sequences for RAM traffic
// and reset-in-WRITE, then random commands against a queue-based model.
module tb_rpn_exec;

    localparam int W    = 8;
    localparam int AW   = 2;
    localparam int DMAX = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic          cmd_ready;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata;
    logic          ram_we;
    logic [W-1:0]  ram_rdata;
    logic [W-1:0]  top;
    logic [AW:0]   depth;
    logic          error;

    rpn_exec #(.WIDTH(W), .AW(AW)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .top       (top),
        .depth     (depth),
        .error     (error)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [DMAX];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // RAM traffic log: a read is the first non-ready, non-write cycle
    int   wr_log[$];
    int   rd_log[$];
    logic prev_ready = 1'b1;
    always @(posedge clk) begin
        prev_ready <= cmd_ready;
        if (!reset) begin
            if (ram_we) wr_log.push_back(int'(ram_addr) * 256 + int'(ram_wdata));
            else if (!cmd_ready && prev_ready) rd_log.push_back(int'(ram_addr));
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    int mq[$];
    bit merr;

    function automatic int m_top();
        return (mq.size() != 0) ? mq[$] : 0;
    endfunction

    // Returns expected cycles between accept edge + 1 and the return to IDLE
    function automatic int model_apply(input int op, input int d);
        int a, b, r;
        case (op)
            0: begin
                if (mq.size() == DMAX) begin merr = 1; return 0; end
                mq.push_back(d);
                return (mq.size() == 1) ? 0 : 1;
            end
            7: begin
                if (mq.size() == 0 || mq.size() == DMAX) begin merr = 1; return 0; end
                mq.push_back(mq[$]);
                return 1;
            end
            1: begin
                if (mq.size() == 0) begin merr = 1; return 0; end
                void'(mq.pop_back());
                return (mq.size() == 0) ? 0 : 2;
            end
            default: begin
                if (mq.size() < 2) begin merr = 1; return 0; end
                b = mq.pop_back();
                a = mq.pop_back();
                case (op)
                    2: r = a + b;
                    3: r = a - b;
                    4: r = a * b;
                    5: r = a & b;
                    default: r = a | b;
                endcase
                mq.push_back(r & 255);
                return 2;
            end
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        mq.delete();
        merr = 0;
        @(negedge clk);
        chk("rst_top", int'(top), 0);
        chk("rst_depth", int'(depth), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_ready", int'(cmd_ready), 1);
    endtask

    task automatic issue(input int op, input int d, output int lat);
        int t;
        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 10) begin @(negedge clk); t++; end
        if (!cmd_ready) chk("ready_timeout_pre", 0, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_data  = W'(d);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_data = W'($urandom);
        lat = 0;
        @(negedge clk);
        while (!cmd_ready && lat < 10) begin @(negedge clk); lat++; end
        if (!cmd_ready) chk("ready_timeout_post", 0, 1);
    endtask

    task automatic run_cmd(input int op, input int d);
        int lat, el;
        issue(op, d, lat);
        el = model_apply(op, d);
        chk("top", int'(top), m_top());
        chk("depth", int'(depth), mq.size());
        chk("error", int'(error), int'(merr));
        chk("latency", lat, el);
    endtask

    typedef struct {
        bit rst;
        int op;
        int data;
        int top;
        int depth;
        bit err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, int op, int d, int t, int dp, bit e);
        vec_t v;
        v.rst = r; v.op = op; v.data = d; v.top = t; v.depth = dp; v.err = e;
        tbl.push_back(v);
    endfunction

    initial begin
        int lat, el;
        for (int i = 0; i < DMAX; i++) mem[i] = '0;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_data = '0;
        merr = 0;
        repeat (2) @(posedge clk);

        add(1, 0, 5,    5,    1, 0);
        add(0, 0, 3,    3,    2, 0);
        add(0, 2, 0,    8,    1, 0);
        add(0, 1, 0,    0,    0, 0);
        add(0, 0, 3,    3,    1, 0);
        add(0, 0, 5,    5,    2, 0);
        add(0, 3, 0,    8'hFE, 1, 0);
        add(0, 0, 8'h10, 8'h10, 2, 0);
        add(0, 0, 8'h20, 8'h20, 3, 0);
        add(0, 4, 0,    0,    2, 0);
        add(0, 1, 0,    8'hFE, 1, 0);
        add(0, 1, 0,    0,    0, 0);
        add(0, 1, 0,    0,    0, 1);
        add(0, 0, 7,    7,    1, 1);
        add(1, 0, 1,    1,    1, 0);
        add(0, 0, 2,    2,    2, 0);
        add(0, 7, 0,    2,    3, 0);
        add(0, 1, 0,    2,    2, 0);
        add(0, 1, 0,    1,    1, 0);
        add(1, 0, 1,    1,    1, 0);
        add(0, 0, 2,    2,    2, 0);
        add(0, 0, 3,    3,    3, 0);
        add(0, 0, 4,    4,    4, 0);
        add(0, 0, 9,    4,    4, 1);
        add(0, 1, 0,    3,    3, 1);
        add(0, 1, 0,    2,    2, 1);
        add(0, 1, 0,    1,    1, 1);
        add(0, 1, 0,    0,    0, 1);
        add(1, 0, 8'hAA, 8'hAA, 1, 0);
        add(0, 5, 0,    8'hAA, 1, 1);
        add(0, 0, 8'h0F, 8'h0F, 2, 1);
        add(0, 6, 0,    8'hAF, 1, 1);
        add(0, 7, 0,    8'hAF, 2, 1);
        add(0, 7, 0,    8'hAF, 3, 1);
        add(0, 7, 0,    8'hAF, 4, 1);
        add(0, 7, 0,    8'hAF, 4, 1);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            issue(tbl[i].op, tbl[i].data, lat);
            el = model_apply(tbl[i].op, tbl[i].data);
            chk($sformatf("v%0d_top", i), int'(top), tbl[i].top);
            chk($sformatf("v%0d_depth", i), int'(depth), tbl[i].depth);
            chk($sformatf("v%0d_error", i), int'(error), int'(tbl[i].err));
            chk($sformatf("v%0d_lat", i), lat, el);
        end

        // RAM traffic: single write of 5 to address 0 for PUSH 5, PUSH 3, ADD
        do_reset();
        wr_log.delete();
        rd_log.delete();
        run_cmd(0, 5);
        run_cmd(0, 3);
        run_cmd(2, 0);
        chk("add_wr_count", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("add_wr0", wr_log[0], 0 * 256 + 5);
        chk("add_rd_count", rd_log.size(), 1);
        if (rd_log.size() > 0) chk("add_rd0", rd_log[0], 0);

        // RAM addressing for DUP and back-to-back POPs
        do_reset();
        wr_log.delete();
        rd_log.delete();
        run_cmd(0, 1);
        run_cmd(0, 2);
        run_cmd(7, 0);
        run_cmd(1, 0);
        run_cmd(1, 0);
        chk("dup_wr_count", wr_log.size(), 2);
        if (wr_log.size() > 1) begin
            chk("dup_wr0", wr_log[0], 0 * 256 + 1);
            chk("dup_wr1", wr_log[1], 1 * 256 + 2);
        end
        chk("dup_rd_count", rd_log.size(), 2);
        if (rd_log.size() > 1) begin
            chk("dup_rd0", rd_log[0], 1);
            chk("dup_rd1", rd_log[1], 0);
        end

        // Reset arriving while a PUSH is in WRITE
        do_reset();
        run_cmd(0, 1);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_data  = 8'h22;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("inwrite_ready_low", int'(cmd_ready), 0);
        reset = 1'b1;
        #1 chk("inwrite_we_suppressed", int'(ram_we), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        mq.delete();
        merr = 0;
        @(negedge clk);
        chk("inwrite_depth", int'(depth), 0);
        chk("inwrite_top", int'(top), 0);
        chk("inwrite_ready", int'(cmd_ready), 1);

        // Random commands against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int op;
            if ($urandom_range(0, 59) == 0) do_reset();
            op = ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 7));
            run_cmd(op, int'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
